// File: rtl/rq_tlp_arbiter.sv
// Packet-atomic round-robin arbiter sharing one PCIe requester-request stream
// between N_REQ TLP sources, with memory-read throttling against MAX_RD.
//
// Ports:
//   user_clk, user_reset_n      clock, asynchronous active-low reset
//   req_t{valid,ready,data,keep,last,user}
//                               per-requester AXI-S TLP inputs (slice i = requester i)
//   m_t{valid,ready,data,keep,last,user}
//                               muxed TLP stream to the RQ adapter
//   rd_cpl_done                 one-cycle pulse: one read request fully completed
//   rd_outstanding              in-flight read request count
//   grant                       one-hot active grant, 0 while idle
module rq_tlp_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 32,
  parameter int unsigned MAX_RD     = 32
) (
  input  logic                        user_clk,
  input  logic                        user_reset_n,
  input  logic [N_REQ-1:0]            req_tvalid,
  output logic [N_REQ-1:0]            req_tready,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_tdata,
  input  logic [N_REQ*KEEP_WIDTH-1:0] req_tkeep,
  input  logic [N_REQ-1:0]            req_tlast,
  input  logic [N_REQ*4-1:0]          req_tuser,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [DATA_WIDTH-1:0]       m_tdata,
  output logic [KEEP_WIDTH-1:0]       m_tkeep,
  output logic                        m_tlast,
  output logic [3:0]                  m_tuser,
  input  logic                        rd_cpl_done,
  output logic [7:0]                  rd_outstanding,
  output logic [N_REQ-1:0]            grant
);

  localparam int unsigned PTR_W  = (N_REQ > 2) ? 2 : 1;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned USER_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gidx;
  logic               first_beat;

  logic [N_REQ-1:0]   rd_hdr;
  logic [N_REQ-1:0]   eligible;
  logic               at_limit;
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   sel;
  logic [N_REQ-1:0]   pick_onehot;
  logic [PTR_W-1:0]   nxt_ptr;
  logic               hs;
  logic               rd_inc;
  logic               rd_dec;
  logic [31:0]        dw0;

  // Header decode: MRd/MRdLk (3DW or 4DW) on each requester's current beat
  always_comb begin
    rd_hdr = '0;
    dw0    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      dw0       = req_tdata[DATA_WIDTH*i +: 32];
      rd_hdr[i] = (dw0[31:30] == 2'b00) && (dw0[28:25] == 4'b0000);
    end
  end

  assign at_limit = (rd_outstanding == CNT_W'(MAX_RD));
  assign eligible = req_tvalid & ~(rd_hdr & {N_REQ{at_limit}});

  // Round-robin pick: first eligible index at or after rr_ptr, wrapping
  always_comb begin
    pick_valid  = 1'b0;
    pick_idx    = '0;
    sel         = '0;
    pick_onehot = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sel = PTR_W'((32'(rr_ptr) + k) % N_REQ);
      if (!pick_valid && eligible[sel]) begin
        pick_valid = 1'b1;
        pick_idx   = sel;
      end
    end
    if (pick_valid) begin
      pick_onehot[pick_idx] = 1'b1;
    end
  end

  // Zero-latency mux of the granted source; quiet outputs while idle
  always_comb begin
    m_tvalid   = 1'b0;
    m_tdata    = '0;
    m_tkeep    = '0;
    m_tlast    = 1'b0;
    m_tuser    = '0;
    req_tready = '0;
    if (state == BUSY) begin
      m_tvalid         = req_tvalid[gidx];
      m_tdata          = req_tdata[DATA_WIDTH*32'(gidx) +: DATA_WIDTH];
      m_tkeep          = req_tkeep[KEEP_WIDTH*32'(gidx) +: KEEP_WIDTH];
      m_tlast          = req_tlast[gidx];
      m_tuser          = req_tuser[USER_W*32'(gidx) +: USER_W];
      req_tready[gidx] = m_tready;
    end
  end

  assign hs      = m_tvalid & m_tready;
  assign nxt_ptr = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);

  // A read is counted when its header beat is accepted downstream
  assign rd_inc = hs & first_beat & rd_hdr[gidx];
  assign rd_dec = rd_cpl_done & (rd_outstanding != '0);

  // Arbitration FSM: grant held from selection until the tlast handshake
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      gidx       <= '0;
      rr_ptr     <= '0;
      first_beat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant      <= pick_onehot;
            gidx       <= pick_idx;
            first_beat <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (hs) begin
            first_beat <= 1'b0;
            if (m_tlast) begin
              rr_ptr <= nxt_ptr;
              grant  <= '0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // In-flight read counter; a completion at zero is ignored
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      rd_outstanding <= '0;
    end else if (rd_inc && !rd_dec) begin
      rd_outstanding <= rd_outstanding + CNT_W'(1);
    end else if (rd_dec && !rd_inc) begin
      rd_outstanding <= rd_outstanding - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rq_tlp_arbiter.sv
// Directed self-checking bench for rq_tlp_arbiter (N_REQ=2, 64-bit data, MAX_RD=2).
module tb_rq_tlp_arbiter;

  localparam int unsigned N_REQ = 2;
  localparam int unsigned DW    = 64;
  localparam int unsigned KW    = DW / 32;
  localparam int unsigned MAXRD = 2;

  localparam logic [63:0] HDR_WR = 64'h1111_2222_4000_0010;
  localparam logic [63:0] HDR_RD = 64'h3333_4444_0000_0001;

  logic              clk;
  logic              rst_n;
  logic [N_REQ-1:0]  req_tvalid;
  logic [N_REQ-1:0]  req_tready;
  logic [DW-1:0]     td [N_REQ];
  logic [KW-1:0]     tk [N_REQ];
  logic [3:0]        tu [N_REQ];
  logic [N_REQ-1:0]  req_tlast;
  logic [N_REQ*DW-1:0] req_tdata;
  logic [N_REQ*KW-1:0] req_tkeep;
  logic [N_REQ*4-1:0]  req_tuser;
  logic              m_tvalid;
  logic              m_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic [3:0]        m_tuser;
  logic              rd_cpl_done;
  logic [7:0]        rd_outstanding;
  logic [N_REQ-1:0]  grant;

  int checks;
  int failures;

  assign req_tdata = {td[1], td[0]};
  assign req_tkeep = {tk[1], tk[0]};
  assign req_tuser = {tu[1], tu[0]};

  rq_tlp_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .MAX_RD     (MAXRD)
  ) dut (
    .user_clk       (clk),
    .user_reset_n   (rst_n),
    .req_tvalid     (req_tvalid),
    .req_tready     (req_tready),
    .req_tdata      (req_tdata),
    .req_tkeep      (req_tkeep),
    .req_tlast      (req_tlast),
    .req_tuser      (req_tuser),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tdata        (m_tdata),
    .m_tkeep        (m_tkeep),
    .m_tlast        (m_tlast),
    .m_tuser        (m_tuser),
    .rd_cpl_done    (rd_cpl_done),
    .rd_outstanding (rd_outstanding),
    .grant          (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (req_tready !== 2'b00) begin failures++; $display("FAIL reset_req_tready got=%b exp=00", req_tready); end
    checks++; if (rd_outstanding !== 8'd0) begin failures++; $display("FAIL reset_rd_out got=%0d exp=0", rd_outstanding); end
    checks++; if (m_tdata !== 64'h0 || m_tkeep !== 2'b00 || m_tlast !== 1'b0 || m_tuser !== 4'h0) begin
      failures++; $display("FAIL reset_mux got=%h/%b/%b/%h exp=0/0/0/0", m_tdata, m_tkeep, m_tlast, m_tuser);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_writer();
    logic [63:0] beats [3];
    beats[0] = HDR_WR;
    beats[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    beats[2] = 64'h0123_4567_89AB_CDEF;
    m_tready = 1'b1;
    req_tvalid[0] = 1'b1; td[0] = beats[0]; tk[0] = 2'b11; tu[0] = 4'hA; req_tlast[0] = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || m_tvalid !== 1'b0) begin failures++; $display("FAIL sw_idle got=%b/%b exp=00/0", grant, m_tvalid); end
    tick();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL sw_grant got=%b exp=01", grant); end
    for (int b = 0; b < 3; b++) begin
      if (b > 0) begin td[0] = beats[b]; req_tlast[0] = (b == 2); tk[0] = (b == 2) ? 2'b01 : 2'b11; tu[0] = 4'(b + 10); #1; end
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== beats[b]) begin
        failures++; $display("FAIL sw_beat%0d got=%b/%h exp=1/%h", b, m_tvalid, m_tdata, beats[b]);
      end
      checks++; if (m_tlast !== (b == 2) || m_tkeep !== tk[0] || m_tuser !== 4'(b == 0 ? 10 : b + 10)) begin
        failures++; $display("FAIL sw_side%0d got=%b/%b/%h", b, m_tlast, m_tkeep, m_tuser);
      end
      checks++; if (req_tready !== 2'b01) begin failures++; $display("FAIL sw_ready%0d got=%b exp=01", b, req_tready); end
      tick();
    end
    req_tvalid[0] = 1'b0; req_tlast[0] = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || m_tvalid !== 1'b0) begin failures++; $display("FAIL sw_end got=%b/%b exp=00/0", grant, m_tvalid); end
    checks++; if (rd_outstanding !== 8'd0) begin failures++; $display("FAIL sw_rd got=%0d exp=0", rd_outstanding); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g [8];
    exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    apply_reset();
    m_tready = 1'b1;
    td[0] = HDR_WR; td[1] = HDR_WR;
    req_tlast = 2'b11;
    req_tvalid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (grant !== exp_g[c]) begin failures++; $display("FAIL fair_cyc%0d got=%b exp=%b", c, grant, exp_g[c]); end
    end
    req_tvalid = 2'b00; req_tlast = 2'b00;
    #1;
  endtask

  task automatic test_backpressure();
    logic [63:0] beats [4];
    int b;
    logic r;
    beats[0] = HDR_WR;
    beats[1] = 64'h1000_0000_0000_0001;
    beats[2] = 64'h2000_0000_0000_0002;
    beats[3] = 64'h3000_0000_0000_0003;
    b = 0;
    r = 1'b1;
    m_tready = 1'b1;
    req_tvalid[1] = 1'b1; td[1] = beats[0]; req_tlast[1] = 1'b0;
    tick();
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL bp_grant got=%b exp=10", grant); end
    for (int c = 0; c < 7; c++) begin
      m_tready = r;
      td[1] = beats[b];
      req_tlast[1] = (b == 3);
      #1;
      checks++; if (req_tready !== {r, 1'b0}) begin failures++; $display("FAIL bp_ready%0d got=%b exp=%b", c, req_tready, {r, 1'b0}); end
      checks++; if (m_tdata !== beats[b] || m_tlast !== (b == 3)) begin
        failures++; $display("FAIL bp_data%0d got=%h/%b exp=%h/%b", c, m_tdata, m_tlast, beats[b], (b == 3));
      end
      tick();
      if (r) b++;
      r = ~r;
    end
    req_tvalid[1] = 1'b0; req_tlast[1] = 1'b0; m_tready = 1'b1;
    #1;
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL bp_end got=%b exp=00", grant); end
  endtask

  task automatic test_read_limit();
    m_tready = 1'b1;
    td[0] = HDR_RD; req_tlast[0] = 1'b1; req_tvalid[0] = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      tick();
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rl_grant%0d got=%b exp=01", n, grant); end
      tick();
      checks++; if (rd_outstanding !== 8'(n)) begin failures++; $display("FAIL rl_cnt%0d got=%0d exp=%0d", n, rd_outstanding, n); end
    end
    tick();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rl_held got=%b exp=00", grant); end
    td[1] = HDR_WR; req_tlast[1] = 1'b1; req_tvalid[1] = 1'b1;
    tick();
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL rl_writer got=%b exp=10", grant); end
    tick();
    req_tvalid[1] = 1'b0; req_tlast[1] = 1'b0;
    tick();
    checks++; if (grant !== 2'b00 || rd_outstanding !== 8'd2) begin
      failures++; $display("FAIL rl_still_held got=%b/%0d exp=00/2", grant, rd_outstanding);
    end
    rd_cpl_done = 1'b1;
    tick();
    rd_cpl_done = 1'b0;
    checks++; if (rd_outstanding !== 8'd1 || grant !== 2'b00) begin
      failures++; $display("FAIL rl_cpl got=%0d/%b exp=1/00", rd_outstanding, grant);
    end
    tick();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rl_third got=%b exp=01", grant); end
    tick();
    req_tvalid[0] = 1'b0; req_tlast[0] = 1'b0;
    checks++; if (rd_outstanding !== 8'd2) begin failures++; $display("FAIL rl_back2 got=%0d exp=2", rd_outstanding); end
  endtask

  task automatic test_simultaneous();
    rd_cpl_done = 1'b1;
    tick();
    rd_cpl_done = 1'b0;
    checks++; if (rd_outstanding !== 8'd1) begin failures++; $display("FAIL sim_pre got=%0d exp=1", rd_outstanding); end
    td[0] = HDR_RD; req_tlast[0] = 1'b1; req_tvalid[0] = 1'b1;
    tick();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL sim_grant got=%b exp=01", grant); end
    rd_cpl_done = 1'b1;
    tick();
    rd_cpl_done = 1'b0; req_tvalid[0] = 1'b0; req_tlast[0] = 1'b0;
    checks++; if (rd_outstanding !== 8'd1) begin failures++; $display("FAIL sim_inc_dec got=%0d exp=1", rd_outstanding); end
    rd_cpl_done = 1'b1;
    tick();
    checks++; if (rd_outstanding !== 8'd0) begin failures++; $display("FAIL sim_to0 got=%0d exp=0", rd_outstanding); end
    tick();
    rd_cpl_done = 1'b0;
    checks++; if (rd_outstanding !== 8'd0) begin failures++; $display("FAIL sim_sat0 got=%0d exp=0", rd_outstanding); end
  endtask

  task automatic test_async_reset();
    m_tready = 1'b1;
    td[0] = HDR_RD; req_tlast[0] = 1'b1; req_tvalid[0] = 1'b1;
    tick();
    tick();
    req_tvalid[0] = 1'b0; req_tlast[0] = 1'b0;
    checks++; if (rd_outstanding !== 8'd1) begin failures++; $display("FAIL ar_pre got=%0d exp=1", rd_outstanding); end
    td[1] = HDR_WR; req_tlast[1] = 1'b0; req_tvalid[1] = 1'b1;
    tick();
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL ar_grant got=%b exp=10", grant); end
    tick();
    td[1] = 64'h5555_6666_7777_8888;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || m_tvalid !== 1'b0 || req_tready !== 2'b00) begin
      failures++; $display("FAIL ar_async got=%b/%b/%b exp=00/0/00", grant, m_tvalid, req_tready);
    end
    checks++; if (rd_outstanding !== 8'd0) begin failures++; $display("FAIL ar_rd got=%0d exp=0", rd_outstanding); end
    td[0] = HDR_WR; td[1] = HDR_WR; req_tlast = 2'b11; req_tvalid = 2'b11;
    #2;
    rst_n = 1'b1;
    tick();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL ar_restart got=%b exp=01", grant); end
    tick();
    req_tvalid = 2'b00; req_tlast = 2'b00;
    #1;
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL ar_done got=%b exp=00", grant); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req_tvalid = '0;
    req_tlast = '0;
    m_tready = 1'b0;
    rd_cpl_done = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      td[i] = '0; tk[i] = '0; tu[i] = '0;
    end
    #2;
    test_reset();
    test_single_writer();
    test_fairness();
    test_backpressure();
    test_read_limit();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
